// File: rtl/nocr_packet_tx_if.sv
// Client request and router link signals of the NoC packet transmitter.
// The master side drives requests and acks; the slave side is the transmitter.
interface nocr_packet_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [1:0]  in_dest;
  logic [7:0]  in_payload;
  logic [12:0] packet;
  logic        resp_ack;
  logic        busy;
  logic        tx_done;
  logic        tx_err;
  logic [1:0]  retry_cnt;
  logic [15:0] sent_count;
  logic [7:0]  drop_count;

  modport master (
    output in_valid, in_type, in_dest, in_payload, resp_ack,
    input  in_ready, packet, busy, tx_done, tx_err, retry_cnt, sent_count, drop_count
  );

  modport slave (
    input  in_valid, in_type, in_dest, in_payload, resp_ack,
    output in_ready, packet, busy, tx_done, tx_err, retry_cnt, sent_count, drop_count
  );
endinterface

// File: rtl/nocr_packet_tx.sv
// Queues client requests and holds each as a router packet on the link until acked, retrying on timeout.
// Push-to-link latency is 2 edges; in_ready falls only while the request FIFO is full.
module nocr_packet_tx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             reset,
  nocr_packet_tx_if.slave  link
);
  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef struct packed {
    logic [7:0] payload;
    logic [1:0] ptype;
    logic [1:0] dest;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          in_ready, push, pop;
  entry_t        head;

  state_t        state_q;
  logic [12:0]   packet_q;
  logic [CW-1:0] tmo_q;
  logic [1:0]    retry_q;
  logic          tx_done_q, tx_err_q;
  logic [15:0]   sent_q;
  logic [7:0]    drop_q;

  assign in_ready = (count_q != DEPTH);
  assign push     = link.in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {link.in_payload, link.in_type, link.in_dest};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      packet_q  <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      sent_q    <= '0;
      drop_q    <= '0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          packet_q <= '0;
          if (pop) begin
            packet_q <= {1'b1, head};
            tmo_q    <= '0;
            retry_q  <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          // An ack on the final timeout cycle still counts as delivered.
          if (link.resp_ack) begin
            tx_done_q <= 1'b1;
            sent_q    <= sent_q + 1'b1;
            packet_q  <= '0;
            state_q   <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              packet_q[12] <= 1'b0;
              retry_q      <= retry_q + 1'b1;
              state_q      <= GAP;
            end else begin
              tx_err_q <= 1'b1;
              if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
              packet_q <= '0;
              state_q  <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        GAP: begin
          packet_q[12] <= 1'b1;
          tmo_q        <= '0;
          state_q      <= SEND;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign link.in_ready   = in_ready;
  assign link.packet     = packet_q;
  assign link.busy       = (state_q != IDLE);
  assign link.tx_done    = tx_done_q;
  assign link.tx_err     = tx_err_q;
  assign link.retry_cnt  = retry_q;
  assign link.sent_count = sent_q;
  assign link.drop_count = drop_q;
endmodule

// File: doc/nocr_packet_tx.md
Name: nocr_packet_tx

Overview:
- Transmit side of the NoC router packet link.
- Accepts payload requests (type, destination router, 8-bit payload) from a local client into a small FIFO.
- Assembles each request into the 13-bit router packet {valid, payload, type, dest} and holds it on the link until the receiving datapath acknowledges.
- Retries on timeout and drops the packet after a bounded number of retries, reporting done/error status.

Parameters:
- FIFO_DEPTH, 4, number of queued requests (power of two, >=2).
- TIMEOUT_CYCLES, 16, cycles a packet is presented per attempt before timing out (>=2).
- MAX_RETRY, 3, retries after the first attempt before the packet is dropped.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  client request valid.
- in_ready  output  1  FIFO can accept; equals (count != FIFO_DEPTH), combinational.
- in_type  input  2  packet type: 00 data, 01 control, 10 response, 11 reserve.
- in_dest  input  2  destination router: 00 nocr1, 01 nocr2, 11 nocr3, 10 nocr4.
- in_payload  input  8  payload byte.
- packet  output  13  link packet: [12] valid, [11:4] payload, [3:2] type, [1:0] dest.
- resp_ack  input  1  one-cycle acknowledge from the receiving side.
- busy  output  1  FSM not in IDLE.
- tx_done  output  1  one-cycle pulse when a packet is acknowledged.
- tx_err  output  1  one-cycle pulse when a packet is dropped.
- retry_cnt  output  2  retries used on the current packet.
- sent_count  output  16  acknowledged packets, wraps at 0xFFFF->0.
- drop_count  output  8  dropped packets, saturates at 0xFF.

Behaviour:
- Reset (reset=0 at posedge):
  - FIFO emptied; FSM to IDLE.
  - packet=0, busy=0, tx_done=0, tx_err=0, retry_cnt=0, sent_count=0, drop_count=0.
  - in_ready=1 after reset.
  - Reset mid-transfer abandons the packet with no tx_err pulse and no count change.
- FIFO:
  - Push when in_valid && in_ready; ordering is first in, first out.
  - Push while full is ignored with no overflow.
  - Push and pop in the same cycle are both performed.
  - Each entry is 12 bits {payload, type, dest}.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - packet=0.
  - If the FIFO is non-empty: pop the head, load packet={1'b1, payload, type, dest}, clear the timeout counter and retry_cnt, go to SEND.
  - Latency: a request pushed at edge N into an empty FIFO has packet[12]=1 after edge N+1.
- SEND:
  - packet is held constant; the timeout counter increments each cycle.
  - resp_ack=1: pulse tx_done next cycle, sent_count+1, packet=0, go to IDLE.
  - No ack and counter==TIMEOUT_CYCLES-1, with retry_cnt<MAX_RETRY: packet[12]=0 with the other bits held, retry_cnt+1, go to GAP.
  - No ack and counter==TIMEOUT_CYCLES-1, with retry_cnt==MAX_RETRY: pulse tx_err, drop_count+1 (saturating), packet=0, go to IDLE.
  - Each attempt presents packet[12]=1 for exactly TIMEOUT_CYCLES cycles.
- GAP:
  - Lasts exactly 1 cycle.
  - packet[12]=1 is restored, the counter is cleared, go to SEND.
  - resp_ack in GAP is ignored.
- Simultaneous events:
  - resp_ack on the timeout cycle: the ack wins, giving tx_done and no retry.
  - resp_ack in IDLE is ignored.
- Back-to-back:
  - The cycle after tx_done/tx_err the FSM is in IDLE with packet=0.
  - The next packet appears one cycle later, so packet[12] deasserts for at least 1 cycle between packets.
- busy=1 in SEND and GAP.
- retry_cnt holds its last value in IDLE until the next load.

Test Plan:
- Reset, push type=01 dest=11 payload=0xA5 -> packet=0x1A57 two edges after push; resp_ack on the 3rd SEND cycle -> tx_done pulse, sent_count=1, packet=0x0000.
- Push type=00 dest=00 payload=0x3C, no ack, TIMEOUT_CYCLES=16, MAX_RETRY=3 -> four 16-cycle windows of 0x13C0, each followed by a 1-cycle 0x03C0 gap (three gaps) -> tx_err pulse, drop_count=1, retry_cnt=3, sent_count=0.
- Fill the FIFO with 4 pushes while the first packet is in SEND (5 total) -> in_ready=0 at count 4, 6th push ignored; packets emerge in push order, each on ack, with packet[12]=0 for >=1 cycle between them; sent_count=5.
- resp_ack on the same cycle the counter reaches 15 on attempt 1 -> tx_done, retry_cnt=0, no GAP entered.
- Assert reset=0 for 1 cycle while in SEND with 2 entries queued -> packet=0, busy=0, FIFO empty, no tx_err pulse, counts 0.
- Ack on the 2nd retry (retry_cnt=2) -> tx_done, sent_count+1, drop_count unchanged; resp_ack pulsed in GAP -> ignored, retry continues.
